branch_predictor: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 38 +++
 rtl/branch_predictor_if.sv | 35 +++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the branch predictor.
//   predstate_t : 2-bit saturating direction counter states
//   btb_entry_t : one branch target buffer entry {valid, tag, target, ctr}
//   sat_step()  : move a counter one step toward the resolved outcome
package cpu_types_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } predstate_t;

  // Sized for the narrowest possible index (pc[31:2]); narrower tags are
  // stored zero-extended so the struct does not depend on table depth.
  localparam int BTB_TAG_BITS = 30;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    predstate_t              ctr;
  } btb_entry_t;

  function automatic predstate_t sat_step(input predstate_t cur, input logic taken);
    predstate_t nxt;
    nxt = cur;
    case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = WEAK_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: signal bundle for the branch predictor.
//   bp : view from the predictor (lookup/update inputs in, predictions out)
//   tb : view from a driver of the predictor (the reverse)
interface branch_predictor_if (input logic CLK);
  logic        RST;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [1:0]  prediction;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        freeze;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  modport bp (
    input  RST, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, freeze,
    output predict_taken, predict_target, prediction, mispredict,
           correct_pc, branch_cnt, miss_cnt
  );

  modport tb (
    output RST, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, freeze,
    input  predict_taken, predict_target, prediction, mispredict,
           correct_pc, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
//   CLK, RST            : clock, synchronous active-high reset
//   lookup_pc           : IF-stage PC; predict_taken/predict_target/prediction
//                         are combinational from it
//   upd_*               : resolved branch (outcome plus the prediction it
//                         carried down the pipe)
//   freeze              : blocks table and statistic writes while high
//   mispredict/correct_pc : combinational redirect info for the hazard unit
//   branch_cnt/miss_cnt : committed branches / committed mispredicts
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  output logic [1:0]  prediction,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        freeze,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDXW = $clog2(ENTRIES);

  function automatic logic [BTB_TAG_BITS-1:0] tag_of(input logic [31:0] pc);
    return BTB_TAG_BITS'(pc >> (IDXW + 2));
  endfunction

  btb_entry_t btb_reg [ENTRIES];
  logic [31:0] branch_cnt_reg;
  logic [31:0] miss_cnt_reg;

  logic [IDXW-1:0] lk_idx;
  logic [IDXW-1:0] upd_idx;
  btb_entry_t      lk_entry;
  btb_entry_t      upd_entry;
  btb_entry_t      wr_entry_next;
  logic            wr_en_next;
  logic            lk_hit;
  logic            upd_hit;
  logic            commit;
  logic [ENTRIES-1:0] wr_sel;

  assign lk_idx  = lookup_pc[IDXW+1:2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign commit  = upd_en & ~freeze;

  // Lookup reads the registered table, so a same-cycle update to the
  // same index is seen only from the next cycle.
  always_comb begin
    lk_entry       = btb_reg[lk_idx];
    lk_hit         = lk_entry.valid && (lk_entry.tag == tag_of(lookup_pc));
    predict_taken  = lk_hit && lk_entry.ctr[1];
    predict_target = predict_taken ? lk_entry.target : lookup_pc + 32'd4;
    prediction     = lk_hit ? lk_entry.ctr : WEAK_NT;
  end

  // Reported regardless of freeze; the hazard unit decides when to act on it.
  assign mispredict = upd_en & ((upd_pred_taken != upd_taken) |
                                (upd_taken & (upd_pred_target != upd_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  always_comb begin
    upd_entry     = btb_reg[upd_idx];
    upd_hit       = upd_entry.valid && (upd_entry.tag == tag_of(upd_pc));
    wr_en_next    = 1'b0;
    wr_entry_next = upd_entry;
    if (commit) begin
      if (upd_hit) begin
        wr_en_next        = 1'b1;
        wr_entry_next.ctr = sat_step(upd_entry.ctr, upd_taken);
        if (upd_taken) wr_entry_next.target = upd_target;
      end else if (upd_taken) begin
        // Allocation evicts whatever aliased branch lived at this index.
        wr_en_next    = 1'b1;
        wr_entry_next = '{valid: 1'b1, tag: tag_of(upd_pc),
                          target: upd_target, ctr: WEAK_T};
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en_next && (upd_idx == IDXW'(gi));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (RST) begin
        btb_reg[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end else if (wr_sel[i]) begin
        btb_reg[i] <= wr_entry_next;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      branch_cnt_reg <= '0;
      miss_cnt_reg   <= '0;
    end else if (commit) begin
      branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (mispredict) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign branch_cnt = branch_cnt_reg;
  assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bus (.CLK(clk));

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK(clk),
    .RST(bus.RST),
    .lookup_pc(bus.lookup_pc),
    .predict_taken(bus.predict_taken),
    .predict_target(bus.predict_target),
    .prediction(bus.prediction),
    .upd_en(bus.upd_en),
    .upd_pc(bus.upd_pc),
    .upd_taken(bus.upd_taken),
    .upd_target(bus.upd_target),
    .upd_pred_taken(bus.upd_pred_taken),
    .upd_pred_target(bus.upd_pred_target),
    .freeze(bus.freeze),
    .mispredict(bus.mispredict),
    .correct_pc(bus.correct_pc),
    .branch_cnt(bus.branch_cnt),
    .miss_cnt(bus.miss_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, 16 slots, tag = pc / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_bcnt, m_mcnt;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(pc[5:2]);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  function automatic bit m_mispredict();
    if (!bus.upd_en) return 1'b0;
    if (bus.upd_pred_taken != bus.upd_taken) return 1'b1;
    return bus.upd_taken && (bus.upd_pred_target != bus.upd_target);
  endfunction

  always @(posedge clk) begin
    int i;
    i = int'(bus.upd_pc[5:2]);
    if (bus.RST) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
      m_bcnt = 0; m_mcnt = 0;
    end else if (bus.upd_en && !bus.freeze) begin
      m_bcnt++;
      if (m_mispredict()) m_mcnt++;
      if (m_hit(bus.upd_pc)) begin
        if (bus.upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = bus.upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = bus.upd_pc >> 6;
        m_tgt[i] = bus.upd_target; m_ctr[i] = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int i;
      bit h, pt;
      i  = int'(bus.lookup_pc[5:2]);
      h  = m_hit(bus.lookup_pc);
      pt = h && (m_ctr[i] >= 2);
      cmp("model predict_taken", 32'(bus.predict_taken), 32'(pt));
      cmp("model predict_target", bus.predict_target, pt ? m_tgt[i] : bus.lookup_pc + 4);
      cmp("model prediction", 32'(bus.prediction), h ? m_ctr[i] : 1);
      cmp("model mispredict", 32'(bus.mispredict), 32'(m_mispredict()));
      cmp("model correct_pc", bus.correct_pc,
          bus.upd_taken ? bus.upd_target : bus.upd_pc + 4);
      cmp("model branch_cnt", bus.branch_cnt, m_bcnt);
      cmp("model miss_cnt", bus.miss_cnt, m_mcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    bus.upd_en = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk;
    bus.upd_target = tgt; bus.upd_pred_taken = ptk; bus.upd_pred_target = ptgt;
  endtask

  task automatic look(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                      input logic [1:0] pr);
    bus.lookup_pc = pc;
    #1;
    cmp("lit predict_taken", 32'(bus.predict_taken), 32'(pt));
    cmp("lit predict_target", bus.predict_target, tgt);
    cmp("lit prediction", 32'(bus.prediction), 32'(pr));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 15) == 0) p[31] = 1'b1;
    return p;
  endfunction

  initial begin
    logic [1:0] exp_nt [3];
    exp_nt[0] = 2'b10; exp_nt[1] = 2'b01; exp_nt[2] = 2'b00;

    bus.RST = 1'b1; bus.lookup_pc = 32'h40; bus.freeze = 1'b0;
    bus.upd_en = 1'b0; bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0;
    bus.upd_pred_taken = 0; bus.upd_pred_target = 0;
    tick();
    chk_en = 1'b1;
    tick();
    bus.RST = 1'b0;

    // Reset state
    look(32'h40, 1'b0, 32'h44, 2'b01);
    cmp("lit reset branch_cnt", bus.branch_cnt, 0);

    // First taken commit allocates; mispredict visible in the same cycle
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    cmp("lit alloc mispredict", 32'(bus.mispredict), 1);
    cmp("lit alloc correct_pc", bus.correct_pc, 32'h100);
    tick();
    bus.upd_en = 1'b0;
    look(32'h40, 1'b1, 32'h100, 2'b10);
    cmp("lit alloc branch_cnt", bus.branch_cnt, 1);
    cmp("lit alloc miss_cnt", bus.miss_cnt, 1);

    // Saturate high
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick();
      bus.upd_en = 1'b0;
      look(32'h40, 1'b1, 32'h100, 2'b11);
    end

    // Walk down to STRONG_NT
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
      tick();
      bus.upd_en = 1'b0;
      look(32'h40, (k == 0), (k == 0) ? 32'h100 : 32'h44, exp_nt[k]);
    end
    cmp("lit sat branch_cnt", bus.branch_cnt, 7);
    cmp("lit sat miss_cnt", bus.miss_cnt, 1);

    // Alias: 0x80 shares index 0 with 0x40 and evicts it
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    bus.upd_en = 1'b0;
    look(32'h40, 1'b0, 32'h44, 2'b01);
    look(32'h80, 1'b1, 32'h200, 2'b10);

    // Freeze holds off the commit for three cycles
    upd(32'h80, 1'b0, 32'h200, 1'b1, 32'h200);
    bus.freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp("lit freeze mispredict", 32'(bus.mispredict), 1);
      tick();
    end
    look(32'h80, 1'b1, 32'h200, 2'b10);
    cmp("lit freeze branch_cnt", bus.branch_cnt, 8);
    bus.freeze = 1'b0;
    #1;
    cmp("lit unfreeze mispredict", 32'(bus.mispredict), 1);
    tick();
    bus.upd_en = 1'b0;
    look(32'h80, 1'b0, 32'h84, 2'b01);
    cmp("lit unfreeze branch_cnt", bus.branch_cnt, 9);
    cmp("lit unfreeze miss_cnt", bus.miss_cnt, 3);

    // Reset concurrent with a taken commit discards the commit
    bus.RST = 1'b1;
    upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    bus.RST = 1'b0; bus.upd_en = 1'b0;
    look(32'h140, 1'b0, 32'h144, 2'b01);
    look(32'h80, 1'b0, 32'h84, 2'b01);
    cmp("lit rst branch_cnt", bus.branch_cnt, 0);
    cmp("lit rst miss_cnt", bus.miss_cnt, 0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 2000; n++) begin
      bus.RST             = ($urandom_range(0, 99) < 2);
      bus.freeze          = ($urandom_range(0, 99) < 20);
      bus.upd_en          = ($urandom_range(0, 99) < 60);
      bus.upd_pc          = rand_pc();
      bus.upd_taken       = $urandom_range(0, 1);
      bus.upd_target      = 32'($urandom_range(1, 4)) << 8;
      bus.upd_pred_taken  = $urandom_range(0, 1);
      bus.upd_pred_target = 32'($urandom_range(1, 4)) << 8;
      bus.lookup_pc       = ($urandom_range(0, 3) == 0) ? bus.upd_pc : rand_pc();
      tick();
    end
    bus.RST = 1'b0; bus.upd_en = 1'b0;
    tick();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
